axi_to_axis_reader: RTL and testbench
=====================================

AXI_TO_AXIS_READER -- requirements
Module: axi_to_axis_reader

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 Parameters SHALL be:
- AXI_ADDR_WIDTH, default 32, AXI address width.
- AXI_DATA_WIDTH, default 64, AXI and stream data width; STRB_W = AXI_DATA_WIDTH/8.
- AXI_ID_WIDTH, default 4, AXI ID width.
- AXI_USER_WIDTH, default 1, AXI user width.
- MAX_BURST, default 16, maximum beats per AR burst, range 1..256.
REQ-003 Ports SHALL be:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_addr  in  AXI_ADDR_WIDTH  start byte address; low log2(STRB_W) bits ignored.
- cmd_beats  in  16  total data beats, 1..65535; 0 is treated as 1.
- m_axi  axi_bus.Master  AXI4 master port.
- m_axis_tdata  out  AXI_DATA_WIDTH  stream data.
- m_axis_tkeep  out  STRB_W  all ones.
- m_axis_tlast  out  1  final beat of the command.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse after the final beat is accepted downstream.
- rd_err  out  1  sticky; set on any r_resp other than OKAY, cleared on the next command accept.

Function
REQ-004 The FSM SHALL have states IDLE, ADDR, DATA, DONE.
- IDLE: cmd_ready=1; on cmd_valid, latch the aligned address and beat count, then go to ADDR.
REQ-005 In ADDR, burst length SHALL be min(remaining, MAX_BURST, (4096 - addr[11:0])/STRB_W); ar_valid=1 until ar_ready, then go to DATA.
REQ-006 AR fields SHALL be:
- ar_len = burst-1; ar_size = log2(STRB_W); ar_burst = INCR (2'b01).
- ar_id, ar_lock, ar_prot, ar_qos, ar_region, ar_user all 0; ar_cache = 4'b0011.
- ar_addr, ar_len and ar_size stable while ar_valid=1.
REQ-007 Only one AR burst SHALL be outstanding; the next AR is issued only after the burst's final R beat is accepted.
REQ-008 In DATA, each accepted R beat SHALL:
- decrement the remaining count;
- advance the address by STRB_W;
- decrement the burst count.
When the burst count reaches 0 (r_last expected), go to ADDR if remaining>0, else DONE.
REQ-009 r_last SHALL be ignored for control; beat counting is authoritative.
REQ-010 The R-to-stream path SHALL be one register stage:
- r_ready = !m_axis_tvalid | m_axis_tready;
- the register loads r_data on r_valid&r_ready;
- no beat is dropped or duplicated under any backpressure pattern.
REQ-011 Stream latency SHALL be 1 cycle from R handshake to m_axis_tvalid.
REQ-012 m_axis_tlast SHALL be 1 only on the beat that brings remaining to 0.
REQ-013 DONE SHALL wait until the last beat leaves the stream register, pulse done for 1 cycle, then go to IDLE.
REQ-014 Write channels SHALL be tied off: aw_valid=0, w_valid=0, b_ready=1, all other AW/W outputs 0.
REQ-015 busy SHALL be 1 in every state except IDLE; a cmd_valid while busy is not accepted.
REQ-016 An error response SHALL not stop the transfer; the data is still forwarded and rd_err is set.

Reset
REQ-017 While aresetn=0, the block SHALL hold:
- FSM in IDLE and counters 0;
- ar_valid=0, r_ready=0, m_axis_tvalid=0, m_axis_tlast=0, done=0, rd_err=0, busy=0, cmd_ready=0.
cmd_ready rises on the first clock after release.
REQ-018 A reset mid-transfer SHALL abandon the command; no done pulse is generated.

Structure
REQ-019 The shared package axis_to_axi_pkg SHALL hold the state enum, BURST_INCR, CACHE_DEFAULT and the 4KB page constant; len_t and size_t come from axi_pkg.
REQ-020 The output register stage SHALL be the sub-module axis_reg_stage; the burst-size calculation stays inline.

Verification
REQ-021 The bench SHALL cover these directed scenarios (DATA_W=64, MAX_BURST=16):
- addr=0x1000, beats=4 -> one AR with len=3, size=3; 4 stream beats; tlast on beat 4; done once.
- addr=0x0000, beats=40 -> ARs with len 15, 15, 7 at 0x000, 0x080, 0x100.
- addr=0x0FF0, beats=4 -> AR len=1 at 0xFF0, then AR len=1 at 0x1000 (4KB split).
- beats=8 with tready toggling every cycle and random r_valid gaps -> 8 beats in order, none lost.
- r_resp=SLVERR on beat 2 of 3 -> all 3 beats forwarded; rd_err=1 until the next cmd accept.
- aresetn low during beat 5 of 10 -> all outputs 0 immediately, no done; a new cmd of 2 beats then completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI4 type definitions used by the bus interface and AXI masters.
// No ports; types and response codes only.
package axi_pkg;
    typedef logic [7:0] len_t;
    typedef logic [2:0] size_t;
    typedef logic [1:0] burst_t;
    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axis_to_axi_pkg.sv
// Constants shared by the AXI-to-stream reader: FSM state encoding,
// fixed AR attribute values and the AXI 4KB page size.
// No ports.
package axis_to_axi_pkg;
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ADDR = 2'd1;
    localparam state_t ST_DATA = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    localparam axi_pkg::burst_t BURST_INCR    = 2'b01;
    localparam logic [3:0]      CACHE_DEFAULT = 4'b0011;
    localparam int              PAGE_BYTES    = 4096;
endpackage

// File: rtl/axi_bus.sv
// AXI4 full bus bundle (all five channels).
// Modports: Master drives AW/W/AR and the B/R ready signals,
// Slave is the mirror image.
interface axi_bus #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 1
);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   aw_id;
    logic [ADDR_WIDTH-1:0] aw_addr;
    axi_pkg::len_t         aw_len;
    axi_pkg::size_t        aw_size;
    axi_pkg::burst_t       aw_burst;
    logic                  aw_lock;
    logic [3:0]            aw_cache;
    logic [2:0]            aw_prot;
    logic [3:0]            aw_qos;
    logic [3:0]            aw_region;
    logic [USER_WIDTH-1:0] aw_user;
    logic                  aw_valid;
    logic                  aw_ready;

    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]     w_strb;
    logic                  w_last;
    logic [USER_WIDTH-1:0] w_user;
    logic                  w_valid;
    logic                  w_ready;

    logic [ID_WIDTH-1:0]   b_id;
    axi_pkg::resp_t        b_resp;
    logic [USER_WIDTH-1:0] b_user;
    logic                  b_valid;
    logic                  b_ready;

    logic [ID_WIDTH-1:0]   ar_id;
    logic [ADDR_WIDTH-1:0] ar_addr;
    axi_pkg::len_t         ar_len;
    axi_pkg::size_t        ar_size;
    axi_pkg::burst_t       ar_burst;
    logic                  ar_lock;
    logic [3:0]            ar_cache;
    logic [2:0]            ar_prot;
    logic [3:0]            ar_qos;
    logic [3:0]            ar_region;
    logic [USER_WIDTH-1:0] ar_user;
    logic                  ar_valid;
    logic                  ar_ready;

    logic [ID_WIDTH-1:0]   r_id;
    logic [DATA_WIDTH-1:0] r_data;
    axi_pkg::resp_t        r_resp;
    logic                  r_last;
    logic [USER_WIDTH-1:0] r_user;
    logic                  r_valid;
    logic                  r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axis_reg_stage.sv
// Single-entry stream register with data + last.
// Ports: aclk/aresetn; upstream s_valid/s_data/s_last/s_ready;
// downstream m_valid/m_data/m_last/m_ready.
// s_ready is high whenever the slot is empty or is draining this cycle,
// so full throughput is kept without a skid buffer.
module axis_reg_stage #(
    parameter int WIDTH = 64
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    input  logic             m_ready
);
    assign s_ready = !m_valid || m_ready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (s_ready) begin
            m_valid <= s_valid;
            m_last  <= s_valid && s_last;
            if (s_valid) m_data <= s_data;
        end
    end
endmodule

// File: rtl/axi_to_axis_reader.sv
// Reads cmd_beats words starting at cmd_addr over AXI4 and forwards them
// as an AXI-Stream with tlast on the final word.
// Ports: aclk/aresetn; cmd_valid/cmd_ready/cmd_addr/cmd_beats command;
// m_axi AXI4 master (read only, write channels idle); m_axis_* stream out;
// busy, done (1-cycle pulse), rd_err (sticky per command).
// Bursts are split at MAX_BURST and at 4KB pages; one burst in flight.
module axi_to_axis_reader
    import axi_pkg::*;
    import axis_to_axi_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 1,
    parameter int MAX_BURST      = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [15:0]                 cmd_beats,
    axi_bus.Master                      m_axi,
    output logic [AXI_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        busy,
    output logic                        done,
    output logic                        rd_err
);
    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int SIZE   = $clog2(STRB_W);

    state_t                    state;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [15:0]               remaining;
    logic [8:0]                burst_cnt;
    logic                      out_of_reset;
    logic [12:0]               page_left;
    logic [12:0]               page_beats;
    logic [15:0]               burst;
    logic                      ar_hs;
    logic                      r_hs;
    logic                      stage_ready;

    // Beats left before the 4KB boundary; addr is word-aligned so this is >= 1.
    assign page_left  = 13'(PAGE_BYTES) - {1'b0, addr[11:0]};
    assign page_beats = page_left >> SIZE;

    always_comb begin
        burst = remaining;
        if (burst > 16'(MAX_BURST)) burst = 16'(MAX_BURST);
        if (burst > {3'b0, page_beats}) burst = {3'b0, page_beats};
    end

    assign ar_hs = m_axi.ar_valid && m_axi.ar_ready;
    assign r_hs  = m_axi.r_valid && m_axi.r_ready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= ST_IDLE;
            addr         <= '0;
            remaining    <= '0;
            burst_cnt    <= '0;
            out_of_reset <= 1'b0;
            rd_err       <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
            case (state)
                ST_IDLE: if (cmd_valid && cmd_ready) begin
                    addr      <= cmd_addr & ~AXI_ADDR_WIDTH'(STRB_W - 1);
                    remaining <= (cmd_beats == 16'd0) ? 16'd1 : cmd_beats;
                    rd_err    <= 1'b0;
                    state     <= ST_ADDR;
                end
                ST_ADDR: if (ar_hs) begin
                    burst_cnt <= burst[8:0];
                    state     <= ST_DATA;
                end
                // Beat counting drives the FSM; r_last is not consulted.
                ST_DATA: if (r_hs) begin
                    remaining <= remaining - 16'd1;
                    addr      <= addr + AXI_ADDR_WIDTH'(STRB_W);
                    burst_cnt <= burst_cnt - 9'd1;
                    if (burst_cnt == 9'd1)
                        state <= (remaining == 16'd1) ? ST_DONE : ST_ADDR;
                end
                // Hold until the final word has drained from the output register.
                default: if (!m_axis_tvalid) state <= ST_IDLE;
            endcase
            if (r_hs && m_axi.r_resp != RESP_OKAY) rd_err <= 1'b1;
        end
    end

    assign cmd_ready = out_of_reset && (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE) && !m_axis_tvalid;

    axis_reg_stage #(.WIDTH(AXI_DATA_WIDTH)) u_out (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_valid (r_hs),
        .s_data  (m_axi.r_data),
        .s_last  (remaining == 16'd1),
        .s_ready (stage_ready),
        .m_valid (m_axis_tvalid),
        .m_data  (m_axis_tdata),
        .m_last  (m_axis_tlast),
        .m_ready (m_axis_tready)
    );

    assign m_axis_tkeep  = '1;
    assign m_axi.r_ready = (state == ST_DATA) && stage_ready;

    assign m_axi.ar_valid  = (state == ST_ADDR);
    assign m_axi.ar_addr   = addr;
    assign m_axi.ar_len    = len_t'(burst - 16'd1);
    assign m_axi.ar_size   = size_t'(SIZE);
    assign m_axi.ar_burst  = BURST_INCR;
    assign m_axi.ar_cache  = CACHE_DEFAULT;
    assign m_axi.ar_id     = {AXI_ID_WIDTH{1'b0}};
    assign m_axi.ar_user   = {AXI_USER_WIDTH{1'b0}};
    assign m_axi.ar_lock   = 1'b0;
    assign m_axi.ar_prot   = 3'b000;
    assign m_axi.ar_qos    = 4'h0;
    assign m_axi.ar_region = 4'h0;

    assign m_axi.aw_valid  = 1'b0;
    assign m_axi.aw_id     = {AXI_ID_WIDTH{1'b0}};
    assign m_axi.aw_addr   = '0;
    assign m_axi.aw_len    = '0;
    assign m_axi.aw_size   = '0;
    assign m_axi.aw_burst  = '0;
    assign m_axi.aw_lock   = 1'b0;
    assign m_axi.aw_cache  = 4'h0;
    assign m_axi.aw_prot   = 3'b000;
    assign m_axi.aw_qos    = 4'h0;
    assign m_axi.aw_region = 4'h0;
    assign m_axi.aw_user   = {AXI_USER_WIDTH{1'b0}};
    assign m_axi.w_valid   = 1'b0;
    assign m_axi.w_data    = '0;
    assign m_axi.w_strb    = '0;
    assign m_axi.w_last    = 1'b0;
    assign m_axi.w_user    = {AXI_USER_WIDTH{1'b0}};
    assign m_axi.b_ready   = 1'b1;

    logic unused_inputs;
    assign unused_inputs = ^{m_axi.aw_ready, m_axi.w_ready, m_axi.b_valid, m_axi.b_id,
                             m_axi.b_resp, m_axi.b_user, m_axi.r_last, m_axi.r_id,
                             m_axi.r_user};
endmodule

// File: tb/tb_axi_to_axis_reader.sv
module tb_axi_to_axis_reader;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int MB = 16;

    typedef struct { logic [31:0] addr; int len; } ar_t;
    typedef struct { logic [63:0] data; logic last; } beat_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [15:0] cmd_beats = '0;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast, tvalid;
    logic        tready = 1'b1;
    logic        busy, done, rd_err;

    always #5 aclk = ~aclk;

    axi_bus #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(4), .USER_WIDTH(1)) axi_if ();

    axi_to_axis_reader #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(4),
        .AXI_USER_WIDTH(1), .MAX_BURST(MB)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
        .m_axi(axi_if),
        .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .busy(busy), .done(done), .rd_err(rd_err)
    );

    int total = 0;
    int bad = 0;
    ar_t   exp_ar[$];
    beat_t exp_beat[$];
    int exp_done = 0;
    int done_cnt = 0;
    int tready_mode = 0;   // 0 always ready, 1 toggle, 2 random
    int gap_pct = 0;
    int err_idx = -1;      // beat index within the command that returns SLVERR
    int r_beat_cnt = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Memory contents seen by the slave: a fixed hash of the byte address.
    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {a ^ 32'h5a5a_0f0f, (a * 32'h9e37_79b1) ^ 32'h0000_1234};
    endfunction

    // Reference: split the command into bursts by MAX_BURST and 4KB pages,
    // and list every word the stream must carry.
    function automatic void model(input logic [31:0] a_in, input logic [15:0] n_in);
        logic [31:0] a;
        int rem, pg, b;
        a   = a_in & ~32'h7;
        rem = (n_in == 0) ? 1 : int'(n_in);
        for (int k = 0; k < rem; k++)
            exp_beat.push_back('{mem_word(a + 32'(k * 8)), (k == rem - 1)});
        while (rem > 0) begin
            pg = (4096 - int'(a % 32'd4096)) / 8;
            b  = rem;
            if (b > MB) b = MB;
            if (b > pg) b = pg;
            exp_ar.push_back('{a, b - 1});
            a   = a + 32'(b * 8);
            rem = rem - b;
        end
    endfunction

    // Monitors: sample on the falling edge, i.e. the handshake of the next rise.
    always @(negedge aclk) begin
        ar_t   ea;
        beat_t eb;
        if (aresetn) begin
            if (axi_if.ar_valid && axi_if.ar_ready) begin
                if (exp_ar.size() == 0) begin
                    total++; bad++;
                    $display("FAIL ar_extra: got AR at %0h, expected none", axi_if.ar_addr);
                end else begin
                    ea = exp_ar.pop_front();
                    chk("ar_addr",  64'(axi_if.ar_addr), 64'(ea.addr));
                    chk("ar_len",   64'(axi_if.ar_len), 64'(ea.len));
                    chk("ar_size",  64'(axi_if.ar_size), 64'd3);
                    chk("ar_burst", 64'(axi_if.ar_burst), 64'd1);
                    chk("ar_cache", 64'(axi_if.ar_cache), 64'd3);
                    chk("ar_id",    64'(axi_if.ar_id), 64'd0);
                end
            end
            if (tvalid && tready) begin
                if (exp_beat.size() == 0) begin
                    total++; bad++;
                    $display("FAIL beat_extra: got %0h, expected none", tdata);
                end else begin
                    eb = exp_beat.pop_front();
                    chk("tdata", tdata, eb.data);
                    chk("tlast", 64'(tlast), 64'(eb.last));
                    chk("tkeep", 64'(tkeep), 64'hff);
                end
            end
            if (done) done_cnt++;
        end
    end

    // AXI read slave with random AR/R stalls and one-outstanding check.
    initial begin
        ar_t bq[$];
        ar_t nb;
        logic arhs, rhs;
        logic [31:0] ar_a, r_addr;
        int ar_l, r_left;
        r_left = 0; r_addr = '0;
        axi_if.ar_ready = 1'b0; axi_if.r_valid = 1'b0; axi_if.r_data = '0;
        axi_if.r_resp = 2'b00; axi_if.r_last = 1'b0; axi_if.r_id = '0; axi_if.r_user = '0;
        axi_if.aw_ready = 1'b0; axi_if.w_ready = 1'b0; axi_if.b_valid = 1'b0;
        axi_if.b_id = '0; axi_if.b_resp = 2'b00; axi_if.b_user = '0;
        forever begin
            @(negedge aclk);
            arhs = axi_if.ar_valid && axi_if.ar_ready;
            rhs  = axi_if.r_valid && axi_if.r_ready;
            ar_a = axi_if.ar_addr;
            ar_l = int'(axi_if.ar_len);
            @(posedge aclk); #1;
            if (!aresetn) begin
                bq.delete();
                r_left = 0;
                axi_if.r_valid  = 1'b0;
                axi_if.ar_ready = 1'b0;
            end else begin
                if (rhs) begin
                    r_left--; r_addr += 32'd8; r_beat_cnt++;
                end
                if (arhs) begin
                    total++;
                    if (r_left != 0 || bq.size() != 0) begin
                        bad++;
                        $display("FAIL ar_outstanding: got AR at %0h with %0d beats open, expected 0", ar_a, r_left);
                    end
                    bq.push_back('{ar_a, ar_l});
                end
                if (r_left == 0 && bq.size() > 0) begin
                    nb = bq.pop_front();
                    r_addr = nb.addr; r_left = nb.len + 1;
                end
                if (r_left > 0) begin
                    if (!(axi_if.r_valid && !rhs))
                        axi_if.r_valid = ($urandom_range(0, 99) >= gap_pct);
                    axi_if.r_data = mem_word(r_addr);
                    axi_if.r_last = (r_left == 1);
                    axi_if.r_resp = (r_beat_cnt == err_idx) ? 2'b10 : 2'b00;
                end else begin
                    axi_if.r_valid = 1'b0;
                end
                axi_if.ar_ready = ($urandom_range(0, 99) >= gap_pct);
            end
        end
    end

    initial begin
        forever begin
            @(posedge aclk); #1;
            case (tready_mode)
                0: tready = 1'b1;
                1: tready = ~tready;
                default: tready = $urandom_range(0, 1) == 1;
            endcase
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [31:0] a, input logic [15:0] n);
        int c;
        @(posedge aclk); #1;
        cmd_valid = 1'b1; cmd_addr = a; cmd_beats = n;
        c = 0;
        do begin @(negedge aclk); c++; end while (!cmd_ready && c < 200);
        if (!cmd_ready) begin
            total++; bad++;
            $display("FAIL cmd_accept: got cmd_ready=0 after %0d cycles, expected 1", c);
        end
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
        chk("busy_after_accept", 64'(busy), 64'd1);
        chk("rd_err_cleared", 64'(rd_err), 64'd0);
    endtask

    task automatic run_cmd(input logic [31:0] a, input logic [15:0] n,
                           input int tm, input int gp, input int ei);
        int c, nb;
        nb = (n == 0) ? 1 : int'(n);
        tready_mode = tm; gap_pct = gp; err_idx = ei; r_beat_cnt = 0;
        model(a, n);
        exp_done++;
        send(a, n);
        c = 0;
        while (done_cnt < exp_done && c < 5000) begin @(negedge aclk); c++; end
        repeat (2) @(negedge aclk);
        chk("done_count", 64'(done_cnt), 64'(exp_done));
        chk("ar_left", 64'(exp_ar.size()), 64'd0);
        chk("beats_left", 64'(exp_beat.size()), 64'd0);
        chk("rd_err_end", 64'(rd_err), 64'(ei >= 0 && ei < nb));
        chk("busy_end", 64'(busy), 64'd0);
    endtask

    initial begin
        int n, ei;
        #12;
        chk("reset_outputs", 64'({axi_if.ar_valid, axi_if.r_ready, tvalid, tlast,
                                  done, rd_err, busy, cmd_ready}), 64'd0);
        repeat (2) @(posedge aclk);
        #3 aresetn = 1'b1;
        #1 chk("cmd_ready_before_clock", 64'(cmd_ready), 64'd0);
        @(posedge aclk); #1;
        chk("cmd_ready_after_clock", 64'(cmd_ready), 64'd1);
        chk("write_tieoff", 64'({axi_if.aw_valid, axi_if.w_valid, axi_if.b_ready}), 64'd1);

        run_cmd(32'h1000, 16'd4, 0, 0, -1);
        run_cmd(32'h0000, 16'd40, 0, 0, -1);
        run_cmd(32'h0ff0, 16'd4, 0, 0, -1);
        run_cmd(32'h2000, 16'd8, 1, 40, -1);
        run_cmd(32'h3000, 16'd3, 0, 20, 1);
        repeat (5) @(posedge aclk);
        #1 chk("rd_err_sticky", 64'(rd_err), 64'd1);
        run_cmd(32'h3107, 16'd0, 2, 10, -1);

        // Reset while the fifth of ten beats is in flight.
        tready_mode = 0; gap_pct = 0; err_idx = -1; r_beat_cnt = 0;
        model(32'h5000, 16'd10);
        send(32'h5000, 16'd10);
        n = 0;
        while (r_beat_cnt < 4 && n < 500) begin @(negedge aclk); n++; end
        @(posedge aclk); #3 aresetn = 1'b0;
        #1 chk("mid_reset_outputs", 64'({axi_if.ar_valid, axi_if.r_ready, tvalid, tlast,
                                         done, rd_err, busy, cmd_ready}), 64'd0);
        exp_ar.delete(); exp_beat.delete();
        repeat (3) @(posedge aclk);
        #3 aresetn = 1'b1;
        repeat (4) @(negedge aclk);
        chk("no_done_after_reset", 64'(done_cnt), 64'(exp_done));
        run_cmd(32'h6000, 16'd2, 0, 0, -1);

        for (int i = 0; i < 12; i++) begin
            n  = $urandom_range(0, 40);
            ei = ($urandom_range(0, 2) == 0) ? $urandom_range(0, (n == 0) ? 0 : n - 1) : -1;
            run_cmd(32'($urandom_range(0, 32'h7fff)), 16'(n), $urandom_range(0, 2),
                    $urandom_range(0, 60), ei);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
